// File: rtl/gem_cluster_lut_scheduler.sv
// rtl/gem_cluster_lut_scheduler.sv - time-multiplexes one cluster-to-wire/half-strip translator over a captured cluster frame
module gem_cluster_lut_scheduler #(
  parameter int NCLUSTER    = 8,
  parameter int IDXBITS     = 3,
  parameter int LUT_LATENCY = 1,
  parameter int CNTBITS     = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    frame_strobe,
  input  logic [NCLUSTER-1:0]     frame_vpf,
  input  logic [NCLUSTER*14-1:0]  frame_cluster,
  input  logic [NCLUSTER*3-1:0]   frame_roll,
  input  logic [NCLUSTER*8-1:0]   frame_pad,
  input  logic [NCLUSTER*3-1:0]   frame_size,
  output logic                    issue_vpf,
  output logic [13:0]             issue_cluster,
  output logic [2:0]              issue_roll,
  output logic [7:0]              issue_pad,
  output logic [2:0]              issue_size,
  output logic [IDXBITS-1:0]      issue_idx,
  output logic                    result_valid,
  output logic [IDXBITS-1:0]      result_idx,
  output logic                    frame_done,
  output logic [IDXBITS:0]        issue_count,
  output logic                    busy,
  output logic [CNTBITS-1:0]      drop_count
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_e;

  state_e state_q, state_d;
  logic [1:0] drain_q, drain_d;

  logic [NCLUSTER-1:0]    pending_q, pending_d;
  logic [NCLUSTER*14-1:0] lat_cluster_q;
  logic [NCLUSTER*3-1:0]  lat_roll_q;
  logic [NCLUSTER*8-1:0]  lat_pad_q;
  logic [NCLUSTER*3-1:0]  lat_size_q;

  logic                   issue_vpf_q, issue_vpf_d;
  logic [13:0]            issue_cluster_q, issue_cluster_d;
  logic [2:0]             issue_roll_q, issue_roll_d;
  logic [7:0]             issue_pad_q, issue_pad_d;
  logic [2:0]             issue_size_q, issue_size_d;
  logic [IDXBITS-1:0]     issue_idx_q, issue_idx_d;
  logic                   frame_done_q, frame_done_d;
  logic [IDXBITS:0]       issue_count_q, issue_count_d;
  logic                   busy_q, busy_d;
  logic [CNTBITS-1:0]     drop_count_q, drop_count_d;
  logic [IDXBITS:0]       dly_q [LUT_LATENCY];

  logic                   accept, drop, do_issue;
  logic [NCLUSTER-1:0]    src_mask, sel_onehot;
  logic [NCLUSTER*14-1:0] src_cluster;
  logic [NCLUSTER*3-1:0]  src_roll;
  logic [NCLUSTER*8-1:0]  src_pad;
  logic [NCLUSTER*3-1:0]  src_size;
  logic [IDXBITS-1:0]     sel_idx;

  assign accept = frame_strobe && (state_q == S_IDLE || state_q == S_DONE);
  assign drop   = frame_strobe && (state_q == S_ISSUE || state_q == S_DRAIN);

  // On an accepted strobe the first issue is taken straight from the inputs so it lands at T+1.
  assign src_mask    = accept ? frame_vpf     : pending_q;
  assign src_cluster = accept ? frame_cluster : lat_cluster_q;
  assign src_roll    = accept ? frame_roll    : lat_roll_q;
  assign src_pad     = accept ? frame_pad     : lat_pad_q;
  assign src_size    = accept ? frame_size    : lat_size_q;
  assign do_issue    = (accept || state_q == S_ISSUE) && (|src_mask);

  always_comb begin
    sel_idx = '0;
    for (int i = NCLUSTER - 1; i >= 0; i--) begin
      if (src_mask[i]) sel_idx = IDXBITS'(i);
    end
    sel_onehot = '0;
    sel_onehot[sel_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // ISSUE leaves once the mask is empty, i.e. the cycle after the last cluster went out.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = (|frame_vpf) ? S_ISSUE : S_DONE;
        else        state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (pending_q == '0) begin
          state_d = S_DRAIN;
          drain_d = 2'(LUT_LATENCY - 1);
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pending_d       = pending_q;
    issue_vpf_d     = 1'b0;
    issue_cluster_d = '0;
    issue_roll_d    = '0;
    issue_pad_d     = '0;
    issue_size_d    = '0;
    issue_idx_d     = '0;
    issue_count_d   = accept ? '0 : issue_count_q;
    drop_count_d    = drop_count_q;
    if (accept) pending_d = '0;
    if (do_issue) begin
      pending_d       = src_mask & ~sel_onehot;
      issue_vpf_d     = 1'b1;
      issue_idx_d     = sel_idx;
      issue_cluster_d = src_cluster[14*sel_idx +: 14];
      issue_roll_d    = src_roll[3*sel_idx +: 3];
      issue_pad_d     = src_pad[8*sel_idx +: 8];
      issue_size_d    = src_size[3*sel_idx +: 3];
      issue_count_d   = issue_count_d + (IDXBITS+1)'(1);
    end
    if (drop && drop_count_q != '1) drop_count_d = drop_count_q + CNTBITS'(1);
    frame_done_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q       <= '0;
      lat_cluster_q   <= '0;
      lat_roll_q      <= '0;
      lat_pad_q       <= '0;
      lat_size_q      <= '0;
      issue_vpf_q     <= 1'b0;
      issue_cluster_q <= '0;
      issue_roll_q    <= '0;
      issue_pad_q     <= '0;
      issue_size_q    <= '0;
      issue_idx_q     <= '0;
      frame_done_q    <= 1'b0;
      issue_count_q   <= '0;
      busy_q          <= 1'b0;
      drop_count_q    <= '0;
    end else begin
      if (accept) begin
        lat_cluster_q <= frame_cluster;
        lat_roll_q    <= frame_roll;
        lat_pad_q     <= frame_pad;
        lat_size_q    <= frame_size;
      end
      pending_q       <= pending_d;
      issue_vpf_q     <= issue_vpf_d;
      issue_cluster_q <= issue_cluster_d;
      issue_roll_q    <= issue_roll_d;
      issue_pad_q     <= issue_pad_d;
      issue_size_q    <= issue_size_d;
      issue_idx_q     <= issue_idx_d;
      frame_done_q    <= frame_done_d;
      issue_count_q   <= issue_count_d;
      busy_q          <= busy_d;
      drop_count_q    <= drop_count_d;
    end
  end

  // Matches the translator latency so result_idx names the slot its outputs belong to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LUT_LATENCY; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= {issue_vpf_q, issue_idx_q};
      for (int i = 1; i < LUT_LATENCY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign issue_vpf     = issue_vpf_q;
  assign issue_cluster = issue_cluster_q;
  assign issue_roll    = issue_roll_q;
  assign issue_pad     = issue_pad_q;
  assign issue_size    = issue_size_q;
  assign issue_idx     = issue_idx_q;
  assign result_valid  = dly_q[LUT_LATENCY-1][IDXBITS];
  assign result_idx    = dly_q[LUT_LATENCY-1][IDXBITS-1:0];
  assign frame_done    = frame_done_q;
  assign issue_count   = issue_count_q;
  assign busy          = busy_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_gem_cluster_lut_scheduler.sv
// tb/tb_gem_cluster_lut_scheduler.sv - randomized directed bench for gem_cluster_lut_scheduler
module tb_gem_cluster_lut_scheduler;
  localparam int NC  = 8;
  localparam int IB  = 3;
  localparam int LAT = 1;
  localparam int CB  = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic frame_strobe = 1'b0;
  logic [NC-1:0]    frame_vpf = '0;
  logic [NC*14-1:0] frame_cluster = '0;
  logic [NC*3-1:0]  frame_roll = '0;
  logic [NC*8-1:0]  frame_pad = '0;
  logic [NC*3-1:0]  frame_size = '0;
  logic             issue_vpf;
  logic [13:0]      issue_cluster;
  logic [2:0]       issue_roll;
  logic [7:0]       issue_pad;
  logic [2:0]       issue_size;
  logic [IB-1:0]    issue_idx;
  logic             result_valid;
  logic [IB-1:0]    result_idx;
  logic             frame_done;
  logic [IB:0]      issue_count;
  logic             busy;
  logic [CB-1:0]    drop_count;

  gem_cluster_lut_scheduler #(.NCLUSTER(NC), .IDXBITS(IB), .LUT_LATENCY(LAT), .CNTBITS(CB)) dut (
    .clock(clock), .reset_n(reset_n), .frame_strobe(frame_strobe), .frame_vpf(frame_vpf),
    .frame_cluster(frame_cluster), .frame_roll(frame_roll), .frame_pad(frame_pad), .frame_size(frame_size),
    .issue_vpf(issue_vpf), .issue_cluster(issue_cluster), .issue_roll(issue_roll), .issue_pad(issue_pad),
    .issue_size(issue_size), .issue_idx(issue_idx), .result_valid(result_valid), .result_idx(result_idx),
    .frame_done(frame_done), .issue_count(issue_count), .busy(busy), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int exp_drop = 0;
  int exp_count = 0;
  logic [NC-1:0] e_vpf;
  logic [13:0]   e_cluster [NC];
  logic [2:0]    e_roll [NC];
  logic [7:0]    e_pad [NC];
  logic [2:0]    e_size [NC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " issue_vpf"}, issue_vpf, 0);
    chk({tag, " issue_cluster"}, issue_cluster, 0);
    chk({tag, " issue_pad"}, issue_pad, 0);
    chk({tag, " issue_idx"}, issue_idx, 0);
    chk({tag, " result_valid"}, result_valid, 0);
    chk({tag, " result_idx"}, result_idx, 0);
    chk({tag, " frame_done"}, frame_done, 0);
    chk({tag, " issue_count"}, issue_count, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " drop_count"}, drop_count, 0);
  endtask

  task automatic junk_inputs();
    frame_vpf = NC'($urandom);
    for (int i = 0; i < NC; i++) begin
      frame_cluster[14*i +: 14] = 14'($urandom);
      frame_roll[3*i +: 3] = 3'($urandom);
      frame_pad[8*i +: 8] = 8'($urandom_range(0, 191));
      frame_size[3*i +: 3] = 3'($urandom);
    end
  endtask

  // Draws a new frame into the reference arrays and drives it with a strobe for the current cycle.
  task automatic prep_frame(input logic [NC-1:0] vpf, input bit tens);
    e_vpf = vpf;
    for (int i = 0; i < NC; i++) begin
      e_cluster[i] = 14'($urandom);
      e_roll[i] = 3'($urandom_range(0, 7));
      e_pad[i] = tens ? 8'(10 * i) : 8'($urandom_range(0, 191));
      e_size[i] = 3'($urandom_range(0, 7));
      frame_cluster[14*i +: 14] = e_cluster[i];
      frame_roll[3*i +: 3] = e_roll[i];
      frame_pad[8*i +: 8] = e_pad[i];
      frame_size[3*i +: 3] = e_size[i];
    end
    frame_vpf = vpf;
    frame_strobe = 1'b1;
  endtask

  // Walks cycles T+1 .. frame_done; drop_at[c] strobes junk in cycle T+c; chain starts the next frame in the done cycle.
  task automatic follow_frame(input logic [31:0] drop_at, input bit chain, input logic [NC-1:0] chain_vpf);
    int order[$];
    int v;
    int last;
    for (int i = 0; i < NC; i++) if (e_vpf[i]) order.push_back(i);
    v = order.size();
    last = (v == 0) ? 1 : v + LAT + 1;
    for (int c = 1; c <= last; c++) begin
      int k;
      int r;
      bit iss;
      bit rv;
      iss = (c <= v);
      k = iss ? order[c-1] : 0;
      r = c - LAT;
      rv = (v > 0) && (r >= 1) && (r <= v);
      chk("issue_vpf", issue_vpf, iss);
      chk("issue_idx", issue_idx, iss ? k : 0);
      chk("issue_pad", issue_pad, iss ? e_pad[k] : 0);
      chk("issue_roll", issue_roll, iss ? e_roll[k] : 0);
      chk("issue_cluster", issue_cluster, iss ? e_cluster[k] : 0);
      chk("issue_size", issue_size, iss ? e_size[k] : 0);
      chk("result_valid", result_valid, rv);
      if (rv) chk("result_idx", result_idx, order[r-1]);
      else    chk("result_idx_idle", result_idx, 0);
      chk("frame_done", frame_done, c == last);
      chk("busy", busy, 1);
      chk("drop_count", drop_count, exp_drop);
      if (c == last) chk("issue_count", issue_count, v);
      frame_strobe = 1'b0;
      junk_inputs();
      if (c == last) begin
        exp_count = v;
        if (chain) prep_frame(chain_vpf, 1'b0);
      end else if (drop_at[c]) begin
        frame_strobe = 1'b1;
        if (exp_drop < (1 << CB) - 1) exp_drop++;
      end
      step();
    end
    frame_strobe = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int c = 0; c < n; c++) begin
      chk("idle issue_vpf", issue_vpf, 0);
      chk("idle result_valid", result_valid, 0);
      chk("idle frame_done", frame_done, 0);
      chk("idle busy", busy, 0);
      chk("idle issue_count", issue_count, exp_count);
      chk("idle drop_count", drop_count, exp_drop);
      step();
    end
  endtask

  initial begin
    step();
    step();
    chk_all_zero("reset");
    reset_n = 1'b1;
    step();
    idle_check(2);

    prep_frame(8'b0000_0101, 1'b0);
    step();
    follow_frame(0, 1'b0, '0);
    idle_check(2);

    prep_frame(8'h00, 1'b0);
    step();
    follow_frame(0, 1'b0, '0);
    idle_check(2);

    prep_frame(8'hFF, 1'b1);
    step();
    follow_frame(32'h0000_0028, 1'b1, NC'($urandom));
    follow_frame(0, 1'b0, '0);
    idle_check(2);

    prep_frame(NC'($urandom), 1'b0);
    step();
    for (int j = 0; j < 8; j++) follow_frame($urandom, j < 7, NC'($urandom));
    idle_check(2);

    prep_frame(8'hFF, 1'b1);
    step();
    frame_strobe = 1'b0;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    exp_drop = 0;
    exp_count = 0;
    step();
    step();
    reset_n = 1'b1;
    idle_check(6);

    for (int j = 0; j < 32; j++) begin
      prep_frame(8'hFF, 1'b0);
      step();
      follow_frame(32'hFFFF_FFFE, 1'b0, '0);
    end
    chk("drop_saturated", drop_count, 255);
    idle_check(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
